// File: rtl/mux_queued_pkg.sv
// Shared sizing helpers for the buffered handshake units: a constant clog2
// and the derived occupancy-counter and pointer widths.
package mux_queued_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // The counter must represent 0..depth inclusive, hence depth+1 states.
  function automatic int count_width(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/elastic_fifo_core.sv
// Circular-buffer FIFO with occupancy count; push and pop may coincide,
// including when full.
module elastic_fifo_core
  import mux_queued_pkg::*;
#(
  parameter int WIDTH   = 34,
  parameter int DEPTH   = 2,
  parameter int COUNT_W = count_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   rd_data,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               push_en;
  logic               pop_en;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == {COUNT_W{1'b0}});
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_en) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {COUNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mux_queued.sv
// Handshake mux that queues each selected token together with its winning
// index; only the selected channel and the index channel are acknowledged.
module mux_queued
  import mux_queued_pkg::*;
#(
  parameter int SIZE        = 2,
  parameter int DATA_TYPE   = 32,
  parameter int SELECT_TYPE = 1,
  parameter int DEPTH       = 2,
  parameter int COUNT_W     = count_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE*DATA_TYPE-1:0] ins,
  input  logic [SIZE-1:0]           ins_valid,
  output logic [SIZE-1:0]           ins_ready,
  input  logic [SELECT_TYPE-1:0]    index,
  input  logic                      index_valid,
  output logic                      index_ready,
  output logic [DATA_TYPE-1:0]      outs,
  output logic [SELECT_TYPE-1:0]    outs_index,
  output logic                      outs_valid,
  input  logic                      outs_ready,
  output logic [COUNT_W-1:0]        count
);

  localparam int WIDTH = DATA_TYPE + SELECT_TYPE;

  logic                 sel_valid;
  logic [DATA_TYPE-1:0] sel_data;
  logic                 sel_ok;
  logic                 pop;
  logic                 push;
  logic                 space;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WIDTH-1:0]     rd_data;

  // Only in-range indices can match a channel, so an out-of-range index leaves sel_valid low.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = {DATA_TYPE{1'b0}};
    for (int i = 0; i < SIZE; i++) begin
      sel_valid = (int'(index) == i) ? ins_valid[i] : sel_valid;
      sel_data  = (int'(index) == i) ? ins[i*DATA_TYPE +: DATA_TYPE] : sel_data;
    end
  end

  assign sel_ok      = index_valid & sel_valid;
  assign outs_valid  = ~fifo_empty;
  assign pop         = outs_valid & outs_ready;
  assign space       = ~fifo_full | pop;
  assign push        = sel_ok & space & ~rst;
  assign index_ready = push;

  always_comb begin
    ins_ready = {SIZE{1'b0}};
    for (int i = 0; i < SIZE; i++) begin
      ins_ready[i] = push & (int'(index) == i);
    end
  end

  elastic_fifo_core #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .COUNT_W (COUNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({index, sel_data}),
    .pop     (pop),
    .rd_data (rd_data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign outs       = rd_data[DATA_TYPE-1:0];
  assign outs_index = rd_data[WIDTH-1 -: SELECT_TYPE];

endmodule
